// File: rtl/d_ff.sv
// Leaf D flip-flop with a synchronous active-low clear, WIDTH bits wide.
// Replicated bitwise to build pipeline registers; each bit is independent.
module d_ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] RESET_VALUE = '0;

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    always_comb begin
        q_d = d;
    end

    // No power-on value: q stays unknown until the first rising edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_d_ff.sv
// Self-checking bench for d_ff: WIDTH=1 and WIDTH=64 instances share clock and reset.
// Table vectors, hand-written mid-cycle sequences and a randomized model comparison.
module tb_d_ff;

    logic        clk;
    logic        reset;
    logic        d1;
    logic        q1;
    logic [63:0] d64;
    logic [63:0] q64;

    int checks;
    int failures;

    typedef struct {
        logic        rst;
        logic        d1;
        logic [63:0] d64;
        logic        e1;
        logic [63:0] e64;
    } vec_t;

    vec_t vecs[$];

    d_ff #(.WIDTH(1)) u_dut1 (
        .clk  (clk),
        .reset(reset),
        .d    (d1),
        .q    (q1)
    );

    d_ff #(.WIDTH(64)) u_dut64 (
        .clk  (clk),
        .reset(reset),
        .d    (d64),
        .q    (q64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Wait for the next rising edge and settle past it before sampling.
    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        exp1;
        logic [63:0] exp64;
        logic        r_rst;
        logic        r_d1;
        logic [63:0] r_d64;

        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        d1       = 1'b1;
        d64      = '1;

        // Reset held low with d=1 for two edges: q cleared and stays cleared.
        edge_step();
        check("reset_edge1_q1", {63'd0, q1}, 64'd0);
        check("reset_edge1_q64", q64, 64'd0);
        edge_step();
        check("reset_edge2_q1", {63'd0, q1}, 64'd0);
        check("reset_edge2_q64", q64, 64'd0);

        // Each row's outputs depend only on the inputs held at that edge.
        vecs.push_back('{1'b1, 1'b1, 64'd420, 1'b1, 64'd420});
        vecs.push_back('{1'b1, 1'b0, 64'd0, 1'b0, 64'd0});
        vecs.push_back('{1'b1, 1'b1, 64'hffff_ffff_ffff_ffff, 1'b1, 64'hffff_ffff_ffff_ffff});
        vecs.push_back('{1'b0, 1'b1, 64'hdead_beef_0123_4567, 1'b0, 64'd0});
        vecs.push_back('{1'b1, 1'b1, 64'h8000_0000_0000_0001, 1'b1, 64'h8000_0000_0000_0001});
        vecs.push_back('{1'b1, 1'b0, 64'h5555_aaaa_5555_aaaa, 1'b0, 64'h5555_aaaa_5555_aaaa});
        vecs.push_back('{1'b0, 1'b0, 64'd420, 1'b0, 64'd0});
        vecs.push_back('{1'b1, 1'b1, 64'd420, 1'b1, 64'd420});
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = vecs[i].rst;
            d1    = vecs[i].d1;
            d64   = vecs[i].d64;
            edge_step();
            check($sformatf("vec%0d_q1", i), {63'd0, q1}, {63'd0, vecs[i].e1});
            check($sformatf("vec%0d_q64", i), q64, vecs[i].e64);
        end

        // Hold: with q=1, d wiggles 0->1->0 between edges; q moves only at the edge.
        @(negedge clk);
        reset = 1'b1;
        d1    = 1'b1;
        d64   = 64'd7;
        edge_step();
        check("hold_pre_q1", {63'd0, q1}, 64'd1);
        d1  = 1'b0;
        d64 = 64'd0;
        #1;
        check("hold_mid0_q1", {63'd0, q1}, 64'd1);
        check("hold_mid0_q64", q64, 64'd7);
        d1  = 1'b1;
        d64 = 64'd9;
        #1;
        check("hold_mid1_q1", {63'd0, q1}, 64'd1);
        d1  = 1'b0;
        d64 = 64'd3;
        #1;
        check("hold_mid2_q64", q64, 64'd7);
        edge_step();
        check("hold_edge_q1", {63'd0, q1}, 64'd0);
        check("hold_edge_q64", q64, 64'd3);

        // Synchronous reset: falling mid-cycle must not clear q before the edge.
        @(negedge clk);
        d1  = 1'b1;
        d64 = 64'd420;
        edge_step();
        check("srst_pre_q1", {63'd0, q1}, 64'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("srst_mid_q1", {63'd0, q1}, 64'd1);
        check("srst_mid_q64", q64, 64'd420);
        edge_step();
        check("srst_edge_q1", {63'd0, q1}, 64'd0);
        check("srst_edge_q64", q64, 64'd0);

        // Release: reset rises mid-cycle with d=1; q stays 0 until the edge samples it.
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rel_mid_q1", {63'd0, q1}, 64'd0);
        check("rel_mid_q64", q64, 64'd0);
        edge_step();
        check("rel_edge_q1", {63'd0, q1}, 64'd1);
        check("rel_edge_q64", q64, 64'd420);

        // Random traffic: the value standing at the edge wins; intermediate glitches do not.
        exp1  = q1 === 1'b1;
        exp64 = 64'd420;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            r_rst = ($urandom_range(0, 5) != 0);
            r_d1  = 1'($urandom);
            r_d64 = {$urandom, $urandom};
            reset = ~r_rst;
            d1    = ~r_d1;
            d64   = ~r_d64;
            #2;
            check("rnd_hold_q64", q64, exp64);
            check("rnd_hold_q1", {63'd0, q1}, {63'd0, exp1});
            reset = r_rst;
            d1    = r_d1;
            d64   = r_d64;
            exp1  = r_rst ? r_d1 : 1'b0;
            exp64 = r_rst ? r_d64 : 64'd0;
            edge_step();
            check("rnd_edge_q64", q64, exp64);
            check("rnd_edge_q1", {63'd0, q1}, {63'd0, exp1});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
